// File: rtl/cbuf_write_arbiter_if.sv
// cbuf_write_arbiter_if: producer-side and buffer-side signals of one shared circular-buffer write port.
interface cbuf_write_arbiter_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_REQ = 4,
    parameter int BURST_W = 4
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*BURST_W-1:0] burst_len;
    logic [NUM_REQ*DATA_W-1:0]  din_bus;
    logic [NUM_REQ-1:0]         dvalid;
    logic [NUM_REQ-1:0]         grant;
    logic [NUM_REQ-1:0]         accept;
    logic                       buf_ready;
    logic                       buf_full;
    logic                       buf_write_enable;
    logic [DATA_W-1:0]          buf_din;
    logic                       busy;
    logic [$clog2(NUM_REQ)-1:0] owner;

    modport master (
        output req, burst_len, din_bus, dvalid, buf_ready, buf_full,
        input  grant, accept, buf_write_enable, buf_din, busy, owner
    );

    modport slave (
        input  req, burst_len, din_bus, dvalid, buf_ready, buf_full,
        output grant, accept, buf_write_enable, buf_din, busy, owner
    );
endinterface

// File: rtl/cbuf_write_arbiter.sv
// cbuf_write_arbiter: round-robin burst arbiter sharing one circular-buffer write port among NUM_REQ producers.
module cbuf_write_arbiter #(
    parameter int DATA_W    = 32,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8,
    parameter int BURST_W   = 4
) (
    input logic                 clk,
    input logic                 rst,
    cbuf_write_arbiter_if.slave bus
);
    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [OW-1:0]      owner_q, owner_d, last_q, last_d, pick;
    logic [BURST_W-1:0] rem_q, rem_d, len, eff_len;
    logic               wr;

    function automatic logic [OW-1:0] nxt(logic [OW-1:0] base, int k);
        return OW'((int'(base) + k) % NUM_REQ);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= OW'(NUM_REQ - 1);
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
        end
    end

    // Walk from farthest to nearest so the first requester after last_q wins.
    always_comb begin
        pick = last_q;
        for (int k = NUM_REQ; k >= 1; k--)
            if (bus.req[nxt(last_q, k)]) pick = nxt(last_q, k);
        len     = bus.burst_len[pick*BURST_W +: BURST_W];
        eff_len = (len == '0) ? BURST_W'(1) : (int'(len) > MAX_BURST) ? BURST_W'(MAX_BURST) : len;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        rem_d   = rem_q;
        if (state_q == IDLE) begin
            if (|bus.req) begin
                state_d = BURST;
                grant_d = NUM_REQ'(1) << pick;
                owner_d = pick;
                rem_d   = eff_len;
            end
        end else begin
            if (wr) rem_d = rem_q - 1'b1;
            if (!bus.req[owner_q] || (wr && rem_q == BURST_W'(1))) begin
                state_d = IDLE;
                grant_d = '0;
                last_d  = owner_q;
            end
        end
    end

    always_comb begin
        wr                   = (state_q == BURST) & bus.dvalid[owner_q] & bus.buf_ready & ~bus.buf_full;
        bus.grant            = grant_q;
        bus.accept           = wr ? grant_q : '0;
        bus.buf_write_enable = wr;
        bus.buf_din          = (state_q == BURST) ? bus.din_bus[owner_q*DATA_W +: DATA_W] : '0;
        bus.busy             = state_q == BURST;
        bus.owner            = owner_q;
    end
endmodule

// File: tb/tb_cbuf_write_arbiter.sv
// tb_cbuf_write_arbiter: table vectors, directed corner sequences and randomized traffic against a reference model.
module tb_cbuf_write_arbiter;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int MB = 8;
    localparam int BW = 4;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    cbuf_write_arbiter_if #(.DATA_W(DW), .NUM_REQ(N), .BURST_W(BW)) bus();
    cbuf_write_arbiter #(.DATA_W(DW), .NUM_REQ(N), .MAX_BURST(MB), .BURST_W(BW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [N-1:0]  req = '0;
    logic [N-1:0]  dvalid = '0;
    logic          buf_ready = 0;
    logic          buf_full = 0;
    logic [BW-1:0] blen [N];
    int            cnt [N];
    int            errors = 0;
    int            checks = 0;
    bit            m_busy;
    int            m_own, m_left, m_last;
    int            n_wr, n_busy;
    logic [DW-1:0] wq [$];
    int            gq [$];

    typedef struct {int who; int len; int exp_wr;} vec_t;
    vec_t tbl [7];

    assign bus.req       = req;
    assign bus.dvalid    = dvalid;
    assign bus.buf_ready = buf_ready;
    assign bus.buf_full  = buf_full;

    // Each producer presents {index, word counter}; the counter advances after an accept.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.burst_len[i*BW +: BW] = blen[i];
            bus.din_bus[i*DW +: DW]   = DW'(i << 24) | DW'(cnt[i]);
        end
    end

    function automatic int eff(int l);
        return l == 0 ? 1 : (l > MB ? MB : l);
    endfunction

    task automatic chk(string nm, logic [DW-1:0] got, logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic mreset();
        m_busy = 0;
        m_own  = 0;
        m_left = 0;
        m_last = N - 1;
        for (int i = 0; i < N; i++) cnt[i] = 0;
    endtask

    task automatic cyc();
        bit wr;
        @(negedge clk);
        wr = m_busy && dvalid[m_own] && buf_ready && !buf_full;
        chk("grant", DW'(bus.grant), DW'(m_busy ? 1 << m_own : 0));
        chk("accept", DW'(bus.accept), DW'(wr ? 1 << m_own : 0));
        chk("write_enable", DW'(bus.buf_write_enable), DW'(wr));
        chk("buf_din", bus.buf_din, m_busy ? DW'(m_own << 24) | DW'(cnt[m_own]) : '0);
        chk("busy", DW'(bus.busy), DW'(m_busy));
        chk("owner", DW'(bus.owner), DW'(m_own));
        if (bus.buf_write_enable) begin
            n_wr++;
            wq.push_back(bus.buf_din);
        end
        if (bus.busy) begin
            n_busy++;
            gq.push_back(int'(bus.owner));
        end
        @(posedge clk);
        if (!rst) mreset();
        else if (!m_busy) begin
            if (req != 0) begin
                for (int k = N; k >= 1; k--)
                    if (req[(m_last + k) % N]) m_own = (m_last + k) % N;
                m_left = eff(int'(blen[m_own]));
                m_busy = 1;
            end
        end else begin
            if (wr) begin
                m_left--;
                cnt[m_own]++;
            end
            if (m_left == 0 || !req[m_own]) begin
                m_busy = 0;
                m_last = m_own;
            end
        end
        #1;
    endtask

    task automatic clr();
        n_wr = 0;
        n_busy = 0;
        wq.delete();
        gq.delete();
    endtask

    task automatic do_reset();
        #2 rst = 0;
        #1 mreset();
        chk("rst_grant", DW'(bus.grant), 0);
        chk("rst_accept", DW'(bus.accept), 0);
        chk("rst_we", DW'(bus.buf_write_enable), 0);
        chk("rst_busy", DW'(bus.busy), 0);
        chk("rst_din", bus.buf_din, 0);
        chk("rst_owner", DW'(bus.owner), 0);
        cyc();
        rst = 1;
    endtask

    initial begin
        int t, base;
        for (int i = 0; i < N; i++) blen[i] = '0;
        mreset();
        do_reset();

        // Single burst of 3 from requester 0
        dvalid = '1;
        buf_ready = 1;
        blen[0] = 3;
        req = 4'b0001;
        clr();
        cyc();
        chk("t1_grant", DW'(bus.grant), 1);
        repeat (3) cyc();
        chk("t1_grant_clear", DW'(bus.grant), 0);
        req = '0;
        chk("t1_writes", DW'(n_wr), 3);
        for (int k = 0; k < 3; k++) chk("t1_word", k < wq.size() ? wq[k] : 'x, DW'(k));
        cyc();

        // Effective burst length: plain, minimum, zero, clamp, exact max, above max
        tbl[0] = '{0, 3, 3};
        tbl[1] = '{1, 1, 1};
        tbl[2] = '{2, 0, 1};
        tbl[3] = '{3, 15, 8};
        tbl[4] = '{0, 8, 8};
        tbl[5] = '{1, 9, 8};
        tbl[6] = '{2, 7, 7};
        for (int v = 0; v < 7; v++) begin
            blen[tbl[v].who] = BW'(tbl[v].len);
            req = N'(1) << tbl[v].who;
            clr();
            cyc();
            chk("tbl_grant", DW'(bus.grant), DW'(1 << tbl[v].who));
            t = 0;
            while (bus.busy && t < 20) begin
                cyc();
                t++;
            end
            chk("tbl_done", DW'(bus.busy), 0);
            chk("tbl_writes", DW'(n_wr), DW'(tbl[v].exp_wr));
            req = '0;
            cyc();
        end

        // Round robin with all requesters held and length 1
        do_reset();
        for (int i = 0; i < N; i++) blen[i] = 1;
        req = '1;
        clr();
        repeat (10) cyc();
        chk("rr_writes", DW'(n_wr), 5);
        chk("rr_grants", DW'(gq.size()), 5);
        for (int k = 0; k < 5; k++) chk("rr_order", DW'(k < gq.size() ? gq[k] : -1), DW'(k % N));

        // Backpressure: buffer full for two cycles after the first word
        req = 4'b0100;
        blen[2] = 4;
        base = cnt[2];
        clr();
        cyc();
        cyc();
        buf_full = 1;
        repeat (2) cyc();
        buf_full = 0;
        repeat (3) cyc();
        chk("bp_writes", DW'(n_wr), 4);
        chk("bp_busy_cycles", DW'(n_busy), 6);
        for (int k = 0; k < 4; k++)
            chk("bp_word", k < wq.size() ? wq[k] : 'x, DW'(2 << 24) | DW'(base + k));
        chk("bp_idle", DW'(bus.busy), 0);
        req = '0;
        cyc();

        // Abort: requester 1 drops req in its first write cycle, then 2 beats 0
        req = 4'b0010;
        blen[1] = 4;
        clr();
        cyc();
        req = 4'b0101;
        cyc();
        chk("abort_idle", DW'(bus.busy), 0);
        chk("abort_writes", DW'(n_wr), 1);
        cyc();
        chk("abort_next_owner", DW'(bus.owner), 2);
        chk("abort_next_grant", DW'(bus.grant), 4);
        req = '0;
        repeat (2) cyc();

        // Reset during the third word of a burst of six
        req = 4'b0001;
        blen[0] = 6;
        repeat (3) cyc();
        #2 rst = 0;
        #1;
        chk("mid_rst_grant", DW'(bus.grant), 0);
        chk("mid_rst_accept", DW'(bus.accept), 0);
        chk("mid_rst_we", DW'(bus.buf_write_enable), 0);
        chk("mid_rst_busy", DW'(bus.busy), 0);
        mreset();
        req = 4'b1001;
        cyc();
        rst = 1;
        cyc();
        chk("post_rst_grant", DW'(bus.grant), 1);
        chk("post_rst_owner", DW'(bus.owner), 0);
        req = '0;
        repeat (8) cyc();

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) req = N'($urandom);
            dvalid = N'($urandom | $urandom);
            buf_ready = $urandom_range(4) != 0;
            buf_full = $urandom_range(4) == 0;
            if ($urandom_range(7) == 0) blen[$urandom_range(N - 1)] = BW'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cbuf_write_arbiter.md
# cbuf_write_arbiter

Round-robin arbiter that shares the single write port of a circular buffer among `NUM_REQ` producers. It grants the port to one producer at a time for a bounded burst of words and forwards that producer's data to the buffer. It honours the buffer's `ready`/`full` backpressure. The block sits between the producer engines and the circular buffer's `write_enable`/`din` inputs, one instance per shared buffer.

## Interface
- `DATA_W`, 32: width of one write word; equals buffer `ROW_SIZE*PAR_WRITE`.
- `NUM_REQ`, 4: number of producers, 2..8.
- `MAX_BURST`, 8: maximum words per grant.
- `BURST_W`, 4: width of each burst-length field; must satisfy 2^BURST_W > MAX_BURST.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req` input NUM_REQ: producer i requests the port; held high until its burst completes.
- `burst_len` input NUM_REQ*BURST_W: field i is producer i's burst length in words; sampled at grant.
- `din_bus` input NUM_REQ*DATA_W: field i is producer i's current word.
- `dvalid` input NUM_REQ: producer i's word is valid this cycle.
- `grant` output NUM_REQ: one-hot current owner, registered.
- `accept` output NUM_REQ: one-hot pulse; the owner's word was written this cycle.
- `buf_ready` input 1: buffer `ready`.
- `buf_full` input 1: buffer `full`.
- `buf_write_enable` output 1: to buffer `write_enable`.
- `buf_din` output DATA_W: to buffer `din`.
- `busy` output 1: a burst is in progress (state BURST).
- `owner` output $clog2(NUM_REQ): index of the current or last owner.

## Operation
- The FSM has two states: IDLE and BURST.
- **IDLE:**
  - When `req` ≠ 0, pick the first set bit searching cyclically from `last_owner+1`.
  - Register the one-hot result into `grant` and its index into `owner`.
  - Load `remaining` with the effective burst length and go to BURST.
  - When `req` = 0, stay in IDLE with `grant` = 0.
- **Effective burst length:**
  - `burst_len` = 0 is treated as 1.
  - Values above MAX_BURST are clamped to MAX_BURST.
- **BURST:**
  - The write condition is `wr = dvalid[owner] & buf_ready & ~buf_full`. It is combinational from the registered state.
  - `buf_write_enable` = `wr`, and `accept[owner]` = `wr`.
  - `buf_din` = `din_bus` field `owner` while in BURST, and 0 otherwise.
  - On `wr`, decrement `remaining`.
  - When `wr` occurs with `remaining` = 1, the burst completes: go to IDLE, clear `grant`, and set `last_owner` = `owner`.
  - No `wr` means `remaining` is held, with no timeout.
- **Abort:**
  - If `req[owner]` is low in BURST, go to IDLE next cycle and set `last_owner` = `owner`.
  - Any `wr` in that same cycle still counts as a written word.
- **Arbitration:**
  - Arbitration only happens in IDLE; a burst is never pre-empted by other requesters.
  - Requests from non-owners are ignored during BURST.
- **Outputs:**
  - `busy` = (state == BURST).
  - `accept` and `buf_write_enable` are never asserted in IDLE.
- **Reset:**
  - All outputs and state are cleared immediately when `rst` falls, even mid-burst.
  - After reset: state IDLE, `grant` = 0, `accept` = 0, `buf_write_enable` = 0, `buf_din` = 0, `busy` = 0.
  - After reset, `owner` = 0 and `last_owner` = NUM_REQ-1, so requester 0 has first priority.
  - Words in flight are not replayed.

## Timing
- **Grant latency:** `req` rises in cycle t (FSM in IDLE) → `grant` is valid in cycle t+1, and the first write can occur in cycle t+1.
- **Throughput:** one word per cycle during a burst when `dvalid`, `buf_ready` and `~buf_full` are held high.
- **Turnaround:** one IDLE cycle between consecutive bursts; a burst of N words occupies N+1 cycles minimum.
- **Write handshake:** `buf_write_enable` and `accept` assert in the same cycle as the word is presented. The producer advances its data on the edge after `accept`.
- **Backpressure:** a `buf_full` or ~`buf_ready` cycle suppresses the write with no loss. The same word stays on `buf_din` until accepted.
- **Simultaneous completion and new request:** the new request is evaluated in the IDLE cycle that follows.

## Test plan
1. **Single burst:**
   - Stimulus: reset, then `req`=4'b0001, `burst_len[0]`=3, `dvalid` and `buf_ready` high.
   - Required: `grant`=0001 one cycle after `req`; then 3 consecutive `buf_write_enable` and `accept[0]` pulses with `buf_din` = words 0,1,2; `grant`=0 after the third pulse.
2. **Round robin:**
   - Stimulus: `req`=4'b1111 held, all `burst_len`=1.
   - Required: grant order 0,1,2,3,0, each grant followed by one IDLE cycle, exactly one write per grant.
3. **Backpressure:**
   - Stimulus: burst of 4 from requester 2; `buf_full` high for 2 cycles after the first word.
   - Required: no write in those 2 cycles; `buf_din` holds word 1; 4 writes total; `busy` stays high throughout.
4. **Abort and clamp:**
   - Abort stimulus: requester 1 with `burst_len`=4 drops `req` after 1 word. Required: IDLE next cycle, exactly 1 write, and requester 2 wins next arbitration over requester 0.
   - Clamp stimulus: `burst_len`=15. Required: exactly 8 writes.
   - Zero-length stimulus: `burst_len`=0. Required: exactly 1 write.
5. **Reset mid-burst:**
   - Stimulus: assert `rst` low during the 3rd word of a burst of 6.
   - Required: `grant`, `accept`, `buf_write_enable` and `busy` go to 0 without waiting for a clock edge; after release with `req`=4'b1001, requester 0 is granted first.
